sync_fifo_ctrl: RTL

Single-clock FIFO, the parametrised successor to async_fifo for same-domain buffering.
- Adds: any depth (not only power-of-two), selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, exact fill level, synchronous flush, sticky overflow/underflow flags.
- Placement: between producer/consumer blocks sharing one clock, where async_fifo's CDC synchronisers add needless latency.

---
 rtl/sync_fifo_ctrl_if.sv | 43 ++++
 rtl/sync_fifo_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle for sync_fifo_ctrl: write side, read side, status and error flags.
// p_peak_level exists only when SYNC_FIFO_PEAK_LEVEL_EN is defined.
interface sync_fifo_ctrl_if #(
  parameter int unsigned BITS = 32,
  parameter int unsigned SIZE = 16
);
  localparam int unsigned LvlW = $clog2(SIZE + 1);

  logic            p_flush;
  logic            p_write_en;
  logic [BITS-1:0] p_write_data;
  logic            p_write_full;
  logic            p_write_almost_full;
  logic            p_read_en;
  logic [BITS-1:0] p_read_data;
  logic            p_read_empty;
  logic            p_read_almost_empty;
  logic [LvlW-1:0] p_level;
  logic            p_overflow;
  logic            p_underflow;
  logic            p_clear_err;
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
  logic [LvlW-1:0] p_peak_level;
`endif

  modport master (
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    input  p_peak_level,
`endif
    output p_flush, p_write_en, p_write_data, p_read_en, p_clear_err,
    input  p_write_full, p_write_almost_full, p_read_data, p_read_empty,
    input  p_read_almost_empty, p_level, p_overflow, p_underflow
  );

  modport slave (
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    output p_peak_level,
`endif
    input  p_flush, p_write_en, p_write_data, p_read_en, p_clear_err,
    output p_write_full, p_write_almost_full, p_read_data, p_read_empty,
    output p_read_almost_empty, p_level, p_overflow, p_underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO of any depth with optional FWFT read, thresholds, flush and sticky errors.
// Optional peak-level tracking is enabled by defining SYNC_FIFO_PEAK_LEVEL_EN.
module sync_fifo_ctrl #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned SIZE      = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = SIZE - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_ctrl_if.slave      bus
);
  localparam int unsigned LvlW = $clog2(SIZE + 1);
  localparam int unsigned PtrW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [LvlW-1:0] LvlFull   = LvlW'(SIZE);
  localparam logic [LvlW-1:0] LvlAfull  = LvlW'(AFULL_TH);
  localparam logic [LvlW-1:0] LvlAempty = LvlW'(AEMPTY_TH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(SIZE - 1);

  if (SIZE < 2) begin : g_bad_size
    $fatal(1, "sync_fifo_ctrl: SIZE must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > SIZE) begin : g_bad_afull
    $fatal(1, "sync_fifo_ctrl: AFULL_TH must be in 1..SIZE");
  end
  if (AEMPTY_TH > SIZE - 1) begin : g_bad_aempty
    $fatal(1, "sync_fifo_ctrl: AEMPTY_TH must be in 0..SIZE-1");
  end

  logic [BITS-1:0] r_mem [SIZE];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [LvlW-1:0] r_level, w_level_d;
  logic            r_full, r_afull, r_empty, r_aempty, r_ovf, r_unf;
  logic            w_ovf_d, w_unf_d, w_wr_acc, w_rd_acc;

  always_comb begin
    w_wr_acc   = bus.p_write_en && !r_full && !bus.p_flush;
    w_rd_acc   = bus.p_read_en && !r_empty && !bus.p_flush;
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_level_d  = r_level;
    if (bus.p_flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_level_d  = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_d = (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) w_rd_ptr_d = (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_level_d = r_level + 1'b1;
        2'b01:   w_level_d = r_level - 1'b1;
        default: w_level_d = r_level;
      endcase
    end
    // A new error event in the same cycle beats the clear.
    w_ovf_d = (bus.p_write_en && r_full)  ? 1'b1 : (bus.p_clear_err ? 1'b0 : r_ovf);
    w_unf_d = (bus.p_read_en  && r_empty) ? 1'b1 : (bus.p_clear_err ? 1'b0 : r_unf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= (AFULL_TH == 0);
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_level  <= w_level_d;
      r_full   <= (w_level_d == LvlFull);
      r_afull  <= (w_level_d >= LvlAfull);
      r_empty  <= (w_level_d == '0);
      r_aempty <= (w_level_d <= LvlAempty);
      r_ovf    <= w_ovf_d;
      r_unf    <= w_unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.p_write_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.p_read_data = r_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_reg_read
    logic [BITS-1:0] r_read_data;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_read_data <= '0;
      else if (w_rd_acc) r_read_data <= r_mem[r_rd_ptr];
    end
    assign bus.p_read_data = r_read_data;
  end

`ifdef SYNC_FIFO_PEAK_LEVEL_EN
  logic [LvlW-1:0] r_peak, w_peak_d;
  always_comb begin
    w_peak_d = r_peak;
    if (bus.p_flush)                w_peak_d = '0;
    else if (bus.p_clear_err)       w_peak_d = w_level_d;
    else if (w_level_d > r_peak)    w_peak_d = w_level_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_peak <= '0;
    else        r_peak <= w_peak_d;
  end
  assign bus.p_peak_level = r_peak;
`else
  // Peak-level tracking disabled: no extra state.
`endif

  assign bus.p_write_full        = r_full;
  assign bus.p_write_almost_full = r_afull;
  assign bus.p_read_empty        = r_empty;
  assign bus.p_read_almost_empty = r_aempty;
  assign bus.p_level             = r_level;
  assign bus.p_overflow          = r_ovf;
  assign bus.p_underflow         = r_unf;
endmodule
